// File: rtl/mono_data_rx_core.sv
// MONOPIX readout front end: token sync, FREEZE/READ/CLK_OUT sequencing,
// serial hit capture and a show-ahead word FIFO for the arbiter FE slot.
module mono_data_rx_core #(
    parameter logic [3:0]  DATA_IDENTIFIER = 4'b0010,
    parameter int unsigned NBITS           = 26,
    parameter int unsigned FREEZE_DLY      = 4,
    parameter int unsigned READ_WIDTH      = 2,
    parameter int unsigned ABUSWIDTH       = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        TOKEN,
    input  logic        DATA,
    output logic        FREEZE,
    output logic        READ,
    output logic        CLK_OUT,
    output logic        BUSY,
    output logic [7:0]  LOST_CNT,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA
);
    localparam int unsigned Depth = 2 ** ABUSWIDTH;
    localparam int unsigned CntW  = 16;
    localparam logic [ABUSWIDTH:0] DepthCnt = (ABUSWIDTH + 1)'(Depth);
    localparam logic [27:0] HitMask = 28'((64'd1 << NBITS) - 64'd1);
    // Settling time after a word so the token drop of the last READ reaches tok_s.
    localparam logic [CntW-1:0] ChkWait = CntW'(3);

    typedef enum logic [2:0] {StIdle, StWfrz, StRd, StShift, StStore, StChk} state_e;

    state_e            state_q, state_d;
    logic              tok_meta_q, tok_s_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;
    logic              ph_q, ph_d;
    logic [27:0]       sr_q, sr_d;
    logic              freeze_q, freeze_d;
    logic              read_q, read_d;
    logic              clk_out_q, clk_out_d;
    logic              push_q, push_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        lost_q, lost_d;

    logic [31:0]          mem [Depth];
    logic [ABUSWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ABUSWIDTH:0]   count_q, count_d;
    logic [31:0]          hold_q, hold_d;
    logic                 fifo_full, fifo_empty, do_pop, do_push;

    assign fifo_full  = (count_q == DepthCnt);
    assign fifo_empty = (count_q == '0);
    assign do_pop     = FIFO_READ && !fifo_empty;
    assign do_push    = push_q && (!fifo_full || do_pop);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        ph_d      = ph_q;
        sr_d      = sr_q;
        freeze_d  = freeze_q;
        read_d    = read_q;
        clk_out_d = clk_out_q;
        push_d    = 1'b0;
        word_d    = word_q;
        lost_d    = lost_q;
        unique case (state_q)
            StIdle: begin
                if (ENABLE && tok_s_q) begin
                    freeze_d = 1'b1;
                    cnt_d    = CntW'(FREEZE_DLY - 1);
                    state_d  = StWfrz;
                end
            end
            StWfrz: begin
                if (cnt_q == '0) begin
                    read_d  = 1'b1;
                    cnt_d   = CntW'(READ_WIDTH - 1);
                    state_d = StRd;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRd: begin
                if (cnt_q == '0) begin
                    read_d  = 1'b0;
                    bit_d   = 5'(NBITS - 1);
                    ph_d    = 1'b0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StShift: begin
                if (!ph_q) begin
                    clk_out_d = 1'b1;
                    ph_d      = 1'b1;
                end else begin
                    // Chip shifts on the CLK_OUT fall, so DATA is sampled just before it.
                    clk_out_d = 1'b0;
                    ph_d      = 1'b0;
                    sr_d      = {sr_q[26:0], DATA};
                    if (bit_q == '0) begin
                        state_d = StStore;
                    end else begin
                        bit_d = bit_q - 5'd1;
                    end
                end
            end
            StStore: begin
                if (fifo_full) begin
                    lost_d = (lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
                end else begin
                    push_d = 1'b1;
                    word_d = {DATA_IDENTIFIER, sr_q & HitMask};
                end
                cnt_d   = ChkWait;
                state_d = StChk;
            end
            StChk: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (ENABLE && tok_s_q) begin
                    read_d  = 1'b1;
                    cnt_d   = CntW'(READ_WIDTH - 1);
                    state_d = StRd;
                end else begin
                    freeze_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + ABUSWIDTH'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + ABUSWIDTH'(1) : rd_ptr_q;
        count_d  = count_q + (ABUSWIDTH + 1)'(do_push) - (ABUSWIDTH + 1)'(do_pop);
        hold_d   = do_pop ? mem[rd_ptr_q] : hold_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            tok_meta_q <= 1'b0;
            tok_s_q    <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            ph_q       <= 1'b0;
            sr_q       <= '0;
            freeze_q   <= 1'b0;
            read_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            push_q     <= 1'b0;
            word_q     <= '0;
            lost_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            tok_meta_q <= TOKEN;
            tok_s_q    <= tok_meta_q;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            ph_q       <= ph_d;
            sr_q       <= sr_d;
            freeze_q   <= freeze_d;
            read_q     <= read_d;
            clk_out_q  <= clk_out_d;
            push_q     <= push_d;
            word_q     <= word_d;
            lost_q     <= lost_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr_q] <= word_q;
        end
    end

    assign FREEZE     = freeze_q;
    assign READ       = read_q;
    assign CLK_OUT    = clk_out_q;
    assign BUSY       = (state_q != StIdle);
    assign LOST_CNT   = lost_q;
    assign FIFO_EMPTY = fifo_empty;
    assign FIFO_DATA  = fifo_empty ? hold_q : mem[rd_ptr_q];

endmodule

// File: tb/tb_mono_data_rx_core.sv
// Directed bench for mono_data_rx_core with a behavioural MONOPIX chip model.
`timescale 1ns/1ps
module tb_mono_data_rx_core;
    logic        CLK = 1'b0;
    logic        RST, ENABLE, TOKEN, DATA, FIFO_READ;
    logic        FREEZE, READ, CLK_OUT, BUSY, FIFO_EMPTY;
    logic [7:0]  LOST_CNT;
    logic [31:0] FIFO_DATA;

    always #5 CLK = ~CLK;

    mono_data_rx_core dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .TOKEN      (TOKEN),
        .DATA       (DATA),
        .FREEZE     (FREEZE),
        .READ       (READ),
        .CLK_OUT    (CLK_OUT),
        .BUSY       (BUSY),
        .LOST_CNT   (LOST_CNT),
        .FIFO_READ  (FIFO_READ),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DATA  (FIFO_DATA)
    );

    typedef struct {
        logic [25:0] hit;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [7];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Chip model: READ loads the next hit, CLK_OUT fall shifts it out MSB first.
    logic [25:0] hit_q [$];
    logic [25:0] chip_sr = '0;
    assign DATA = chip_sr[25];

    always @(posedge READ) begin
        if (hit_q.size() > 0) chip_sr = hit_q.pop_front();
        else chip_sr = '0;
        if (hit_q.size() == 0) TOKEN = 1'b0;
    end

    always @(negedge CLK_OUT) chip_sr = {chip_sr[24:0], 1'b0};

    always @(posedge CLK) cyc <= cyc + 1;

    int   tok_cyc, fr_rise, fr_falls, rd_fall, rd_high, co_rises, co_first, co_fall, ef_fall;
    int   rd_rises [$];
    logic fr_p = 1'b0, rd_p = 1'b0, co_p = 1'b0, ef_p = 1'b0;

    always @(negedge CLK) begin
        if (FREEZE === 1'b1 && fr_p !== 1'b1) fr_rise = cyc;
        if (FREEZE === 1'b0 && fr_p === 1'b1) fr_falls++;
        if (READ === 1'b1 && rd_p !== 1'b1) rd_rises.push_back(cyc);
        if (READ === 1'b0 && rd_p === 1'b1) rd_fall = cyc;
        if (READ === 1'b1) rd_high++;
        if (CLK_OUT === 1'b1 && co_p !== 1'b1) begin
            co_rises++;
            if (co_first < 0) co_first = cyc;
        end
        if (CLK_OUT === 1'b0 && co_p === 1'b1) co_fall = cyc;
        if (FIFO_EMPTY === 1'b0 && ef_p === 1'b1) ef_fall = cyc;
        fr_p = FREEZE;
        rd_p = READ;
        co_p = CLK_OUT;
        ef_p = FIFO_EMPTY;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        rd_rises.delete();
        fr_rise  = -1;
        fr_falls = 0;
        rd_fall  = -1;
        rd_high  = 0;
        co_rises = 0;
        co_first = -1;
        co_fall  = -1;
        ef_fall  = -1;
    endtask

    task automatic post_hit(input logic [25:0] h);
        @(posedge CLK);
        #1;
        hit_q.push_back(h);
        TOKEN   = 1'b1;
        tok_cyc = cyc;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        repeat (6) @(posedge CLK);
        for (int i = 0; i < 4000 && !done; i++) begin
            tick();
            if (BUSY === 1'b0) done = 1'b1;
        end
        if (!done) chk("idle_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic wait_co(input int n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (co_rises >= n) done = 1'b1;
        end
        if (!done) chk("shift_timeout", co_rises, n);
    endtask

    task automatic pop_chk(input string name, input logic [31:0] exp);
        tick();
        chk({name, "_nonempty"}, {31'd0, FIFO_EMPTY}, 32'd0);
        chk(name, FIFO_DATA, exp);
        FIFO_READ = 1'b1;
        @(posedge CLK);
        #1;
        FIFO_READ = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_freeze"}, {31'd0, FREEZE}, 32'd0);
        chk({tag, "_read"}, {31'd0, READ}, 32'd0);
        chk({tag, "_clk_out"}, {31'd0, CLK_OUT}, 32'd0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_lost"}, {24'd0, LOST_CNT}, 32'd0);
        chk({tag, "_empty"}, {31'd0, FIFO_EMPTY}, 32'd1);
        chk({tag, "_data"}, FIFO_DATA, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] ov [10];
        int          first_rd;

        vt[0] = '{26'h2AAAAAA, 32'h22AAAAAA};
        vt[1] = '{26'h0000001, 32'h20000001};
        vt[2] = '{26'h3FFFFFF, 32'h23FFFFFF};
        vt[3] = '{26'h1234567, 32'h21234567};
        vt[4] = '{26'h0F0F0F0, 32'h20F0F0F0};
        vt[5] = '{26'h2345678, 32'h22345678};
        vt[6] = '{26'h1555555, 32'h21555555};

        RST = 1'b1;
        ENABLE = 1'b1;
        TOKEN = 1'b1;
        FIFO_READ = 1'b0;
        clear_mon();

        // Reset held with TOKEN high: no READ may appear.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_read", {31'd0, READ}, 32'd0);
        end
        chk_reset_outputs("rst");
        RST = 1'b0;
        TOKEN = 1'b0;
        repeat (4) tick();
        chk("post_rst_no_read", rd_rises.size(), 0);

        // Single hits from the table, each with full latency checks.
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            post_hit(vt[k].hit);
            wait_idle();
            first_rd = (rd_rises.size() > 0) ? rd_rises[0] : -100;
            chk("tok_to_freeze", fr_rise - tok_cyc, 3);
            chk("freeze_to_read", first_rd - fr_rise, 4);
            chk("read_count", rd_rises.size(), 1);
            chk("read_width", rd_high, 2);
            chk("read_to_clk", co_first - rd_fall, 1);
            chk("clk_pulses", co_rises, 26);
            chk("clk_to_empty", ef_fall - co_fall, 2);
            chk("freeze_end", {31'd0, FREEZE}, 32'd0);
            pop_chk("single_word", vt[k].exp);
            tick();
            chk("empty_after_pop", {31'd0, FIFO_EMPTY}, 32'd1);
            chk("data_hold", FIFO_DATA, vt[k].exp);
        end

        // Burst of three hits under one FREEZE.
        clear_mon();
        for (int k = 1; k < 4; k++) post_hit(vt[k].hit);
        wait_idle();
        chk("burst_reads", rd_rises.size(), 3);
        if (rd_rises.size() == 3) begin
            chk("burst_period1", rd_rises[1] - rd_rises[0], 59);
            chk("burst_period2", rd_rises[2] - rd_rises[1], 59);
        end
        chk("burst_freeze_falls", fr_falls, 1);
        for (int k = 1; k < 4; k++) pop_chk("burst_word", vt[k].exp);

        // Overflow: 10 hits into an 8-deep FIFO without popping.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            ov[i] = 26'(i * 32'h111111 + 1);
            post_hit(ov[i]);
        end
        wait_idle();
        chk("ovf_reads", rd_rises.size(), 10);
        chk("ovf_lost", {24'd0, LOST_CNT}, 32'd2);
        for (int i = 0; i < 8; i++) pop_chk("ovf_word", {4'b0010, 2'b00, ov[i]});
        tick();
        chk("ovf_empty_after_8", {31'd0, FIFO_EMPTY}, 32'd1);

        // ENABLE dropped mid-shift with a second hit still pending.
        clear_mon();
        post_hit(vt[4].hit);
        post_hit(vt[5].hit);
        wait_co(5);
        ENABLE = 1'b0;
        wait_idle();
        chk("en_low_reads", rd_rises.size(), 1);
        chk("en_low_freeze", {31'd0, FREEZE}, 32'd0);
        pop_chk("en_low_word", vt[4].exp);
        repeat (30) tick();
        chk("en_low_no_more_read", rd_rises.size(), 1);

        // Reset at bit 10 of the pending hit's shift.
        clear_mon();
        ENABLE = 1'b1;
        wait_co(16);
        RST = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        RST = 1'b0;
        repeat (70) tick();
        chk("midrst_no_push", {31'd0, FIFO_EMPTY}, 32'd1);
        chk("midrst_no_restart", rd_rises.size(), 1);

        clear_mon();
        post_hit(vt[6].hit);
        wait_idle();
        chk("restart_clk_pulses", co_rises, 26);
        chk("restart_lost", {24'd0, LOST_CNT}, 32'd0);
        pop_chk("restart_word", vt[6].exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
